// File: rtl/ring_phase_monitor_if.sv
// Bundle between the 4-bit one-hot ring counter and its phase supervisor.
// The master side owns the ring outputs and Clear. The slave side is the
// monitor, which drives the seed request and the status record.
interface ring_phase_monitor_if #(
  parameter int REV_WIDTH = 8,
  parameter int ERR_WIDTH = 4
);
  logic [3:0]           Phase;
  logic                 Clear;
  logic                 Preset;
  logic                 Locked;
  logic                 Fault;
  logic [1:0]           Slot;
  logic [REV_WIDTH-1:0] Revolutions;
  logic                 Wrap;
  logic [ERR_WIDTH-1:0] ErrCount;

  modport master (
    output Phase, Clear,
    input  Preset, Locked, Fault, Slot, Revolutions, Wrap, ErrCount
  );

  modport slave (
    input  Phase, Clear,
    output Preset, Locked, Fault, Slot, Revolutions, Wrap, ErrCount
  );
endinterface

// File: rtl/ring_phase_monitor.sv
// Supervisor for a 4-bit one-hot ring counter. It seeds the ring through
// Preset, checks the rotation 1000->0100->0010->0001 every cycle, and reports
// the slot index, the lock state, a revolution count and a saturating
// illegal-phase count. Every output decodes from registers only.
module ring_phase_monitor #(
  parameter int REV_WIDTH    = 8,
  parameter int ERR_WIDTH    = 4,
  parameter int SYNC_TIMEOUT = 15
)(
  input  logic Clock,
  input  logic Resetn,
  ring_phase_monitor_if.slave bus
);
  // The timer counts 0 .. SYNC_TIMEOUT-1 while in SYNC, so it never needs to
  // hold SYNC_TIMEOUT itself.
  localparam int TW = (SYNC_TIMEOUT < 2) ? 1 : $clog2(SYNC_TIMEOUT);
  localparam logic [TW-1:0] TMR_LAST = TW'(SYNC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_SYNC, S_RUN, S_FAULT
  } state_t;

  state_t               state, state_nxt;
  logic [3:0]           phase_q;
  logic [3:0]           expected;
  logic [TW-1:0]        tmr;
  logic [REV_WIDTH-1:0] rev;
  logic [ERR_WIDTH-1:0] err;
  logic                 wrap_q;
  logic                 phase_oh;
  logic                 err_evt;
  logic                 rev_inc;
  logic [1:0]           slot_enc;

  // Single hot bit (zero is not one-hot).
  assign phase_oh = (bus.Phase != 4'b0000) &&
                    ((bus.Phase & (bus.Phase - 4'd1)) == 4'b0000);

  // The phase the ring must show this cycle if it rotated legally.
  assign expected = {phase_q[0], phase_q[3:1]};

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic and the single-cycle error / revolution events.
  always_comb begin
    state_nxt = state;
    err_evt   = 1'b0;
    rev_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.Phase == 4'b0000) state_nxt = S_SEED;
        else if (phase_oh)        state_nxt = S_SYNC;
        else begin
          state_nxt = S_FAULT;
          err_evt   = 1'b1;
        end
      end
      S_SEED: state_nxt = S_SYNC;
      S_SYNC: begin
        // Seeing 1000 wins even on the final timeout cycle.
        if (bus.Phase == 4'b1000) state_nxt = S_RUN;
        else if (bus.Phase != 4'b0000 && !phase_oh) begin
          state_nxt = S_FAULT;
          err_evt   = 1'b1;
        end else if (tmr == TMR_LAST) begin
          state_nxt = S_FAULT;
          err_evt   = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.Phase != expected) begin
          state_nxt = S_FAULT;
          err_evt   = 1'b1;
        end else if (bus.Phase == 4'b1000 && phase_q == 4'b0001) begin
          rev_inc = 1'b1;
        end
      end
      S_FAULT: if (bus.Clear) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Phase history, sampled every cycle regardless of state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) phase_q <= 4'b0000;
    else         phase_q <= bus.Phase;
  end

  // SYNC dwell timer. It is held at zero outside SYNC, so it restarts on entry.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                tmr <= '0;
    else if (state != S_SYNC)   tmr <= '0;
    else                        tmr <= tmr + TW'(1);
  end

  // Revolution counter and rollover pulse. Clear beats an increment and
  // suppresses the Wrap it would have caused.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rev    <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= rev_inc && !bus.Clear && (rev == '1);
      if (bus.Clear)    rev <= '0;
      else if (rev_inc) rev <= rev + REV_WIDTH'(1);
    end
  end

  // Saturating illegal-phase counter. Only Resetn clears it.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                    err <= '0;
    else if (err_evt && err != '1)  err <= err + ERR_WIDTH'(1);
  end

  // Slot comes from the rotated history, so it names the ring position for
  // the current cycle without a combinational path from Phase.
  always_comb begin
    slot_enc = 2'd0;
    case (expected)
      4'b1000: slot_enc = 2'd3;
      4'b0100: slot_enc = 2'd2;
      4'b0010: slot_enc = 2'd1;
      default: slot_enc = 2'd0;
    endcase
  end

  assign bus.Preset      = (state == S_SEED);
  assign bus.Locked      = (state == S_RUN);
  assign bus.Fault       = (state == S_FAULT);
  assign bus.Slot        = (state == S_RUN) ? slot_enc : 2'd0;
  assign bus.Revolutions = rev;
  assign bus.Wrap        = wrap_q;
  assign bus.ErrCount    = err;
endmodule

// File: tb/tb_ring_phase_monitor.sv
// Bench for ring_phase_monitor. A behavioural ring counter drives Phase and
// can be cleared, stalled or overridden with an arbitrary pattern.
module tb_ring_phase_monitor;
  localparam int RW = 2;
  localparam int EW = 4;
  localparam int T  = 15;

  logic Clock = 1'b0;
  logic Resetn;
  logic [3:0] ring;
  logic [3:0] ovr_val;
  logic ring_clr, ring_hold, ovr_en;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int exp_w[$];

  ring_phase_monitor_if #(.REV_WIDTH(RW), .ERR_WIDTH(EW)) bus();

  ring_phase_monitor #(.REV_WIDTH(RW), .ERR_WIDTH(EW), .SYNC_TIMEOUT(T)) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .bus(bus)
  );

  always #5 Clock = ~Clock;

  // Ring counter model: Preset loads 1000, otherwise rotate right.
  always @(posedge Clock) begin
    if (ring_clr)        ring <= 4'b0000;
    else if (ring_hold)  ring <= ring;
    else if (bus.Preset) ring <= 4'b1000;
    else                 ring <= {ring[0], ring[3:1]};
  end

  assign bus.Phase = ovr_en ? ovr_val : ring;

  // Leaves the bench at the negedge of cycle 0 with the ring at 0000.
  task automatic do_reset();
    @(negedge Clock);
    Resetn = 1'b0; ring_clr = 1'b1; ring_hold = 1'b0; ovr_en = 1'b0; bus.Clear = 1'b0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1; ring_clr = 1'b0;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; ring_clr = 1'b1; ring_hold = 1'b0; ovr_en = 1'b0; ovr_val = 4'b0000; bus.Clear = 1'b0;
    repeat (2) @(negedge Clock);
    checks++; if (bus.Preset !== 1'b0) begin errors++; $display("FAIL reset_preset got=%b want=0", bus.Preset); end
    checks++; if (bus.Locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b want=0", bus.Locked); end
    checks++; if (bus.Fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b want=0", bus.Fault); end
    checks++; if (bus.Slot !== 2'd0) begin errors++; $display("FAIL reset_slot got=%0d want=0", bus.Slot); end
    checks++; if (bus.Revolutions !== 2'd0) begin errors++; $display("FAIL reset_rev got=%0d want=0", bus.Revolutions); end
    checks++; if (bus.Wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b want=0", bus.Wrap); end
    checks++; if (bus.ErrCount !== 4'd0) begin errors++; $display("FAIL reset_err got=%0d want=0", bus.ErrCount); end
  endtask

  task automatic test_clean_start();
    int e;
    do_reset();
    checks++; if (bus.Preset !== 1'b0) begin errors++; $display("FAIL start_c0_preset got=%b want=0", bus.Preset); end
    @(negedge Clock);
    checks++; if (bus.Preset !== 1'b1) begin errors++; $display("FAIL start_c1_preset got=%b want=1", bus.Preset); end
    checks++; if (bus.Locked !== 1'b0) begin errors++; $display("FAIL start_c1_locked got=%b want=0", bus.Locked); end
    @(negedge Clock);
    checks++; if (bus.Preset !== 1'b0) begin errors++; $display("FAIL start_c2_preset got=%b want=0", bus.Preset); end
    checks++; if (bus.Locked !== 1'b0) begin errors++; $display("FAIL start_c2_locked got=%b want=0", bus.Locked); end
    for (int k = 0; k < 6; k++) exp_q.push_back((6 - k) % 4);
    for (int k = 0; k < 6; k++) begin
      @(negedge Clock);
      e = exp_q.pop_front();
      checks++; if (bus.Locked !== 1'b1) begin errors++; $display("FAIL start_locked c%0d got=%b want=1", k + 3, bus.Locked); end
      checks++; if (bus.Slot !== e[1:0]) begin errors++; $display("FAIL start_slot c%0d got=%0d want=%0d", k + 3, bus.Slot, e); end
      checks++; if (bus.Preset !== 1'b0) begin errors++; $display("FAIL start_preset c%0d got=%b want=0", k + 3, bus.Preset); end
    end
  endtask

  task automatic test_revolutions();
    int e, w, nwrap;
    nwrap = 0;
    do_reset();
    for (int c = 3; c <= 19; c++) begin
      exp_q.push_back((c >= 7) ? (((c - 7) / 4 + 1) % 4) : 0);
      exp_w.push_back((c == 19) ? 1 : 0);
    end
    repeat (2) @(negedge Clock);
    for (int c = 3; c <= 19; c++) begin
      @(negedge Clock);
      e = exp_q.pop_front();
      w = exp_w.pop_front();
      if (bus.Wrap === 1'b1) nwrap++;
      checks++; if (bus.Revolutions !== e[RW-1:0]) begin errors++; $display("FAIL rev_count c%0d got=%0d want=%0d", c, bus.Revolutions, e); end
      checks++; if (bus.Wrap !== w[0]) begin errors++; $display("FAIL rev_wrap c%0d got=%b want=%0d", c, bus.Wrap, w); end
    end
    checks++; if (nwrap != 1) begin errors++; $display("FAIL rev_wrap_pulses got=%0d want=1", nwrap); end
  endtask

  task automatic test_illegal();
    do_reset();
    repeat (3) @(negedge Clock);
    checks++; if (bus.Locked !== 1'b1) begin errors++; $display("FAIL ill_pre_locked got=%b want=1", bus.Locked); end
    ovr_val = 4'b0110; ovr_en = 1'b1;
    @(negedge Clock);
    ovr_en = 1'b0;
    checks++; if (bus.Fault !== 1'b1) begin errors++; $display("FAIL ill_fault got=%b want=1", bus.Fault); end
    checks++; if (bus.Locked !== 1'b0) begin errors++; $display("FAIL ill_locked got=%b want=0", bus.Locked); end
    checks++; if (bus.Slot !== 2'd0) begin errors++; $display("FAIL ill_slot got=%0d want=0", bus.Slot); end
    checks++; if (bus.ErrCount !== 4'd1) begin errors++; $display("FAIL ill_err got=%0d want=1", bus.ErrCount); end
    bus.Clear = 1'b1;
    @(negedge Clock);
    bus.Clear = 1'b0;
    checks++; if (bus.Fault !== 1'b0) begin errors++; $display("FAIL ill_clear_fault got=%b want=0", bus.Fault); end
    checks++; if (bus.Locked !== 1'b0) begin errors++; $display("FAIL ill_idle_locked got=%b want=0", bus.Locked); end
    @(negedge Clock);
    checks++; if (bus.Locked !== 1'b0) begin errors++; $display("FAIL ill_sync_locked got=%b want=0", bus.Locked); end
    checks++; if (bus.Preset !== 1'b0) begin errors++; $display("FAIL ill_sync_preset got=%b want=0", bus.Preset); end
    @(negedge Clock);
    checks++; if (bus.Locked !== 1'b1) begin errors++; $display("FAIL ill_relock got=%b want=1", bus.Locked); end
    checks++; if (bus.Slot !== 2'd2) begin errors++; $display("FAIL ill_relock_slot got=%0d want=2", bus.Slot); end
    checks++; if (bus.ErrCount !== 4'd1) begin errors++; $display("FAIL ill_err_hold got=%0d want=1", bus.ErrCount); end
  endtask

  task automatic test_timeout();
    int f, p;
    do_reset();
    ring_hold = 1'b1;
    for (int c = 1; c <= T + 4; c++) begin
      exp_q.push_back((c >= 2 + T) ? 1 : 0);
      exp_w.push_back((c == 1) ? 1 : 0);
    end
    for (int c = 1; c <= T + 4; c++) begin
      @(negedge Clock);
      f = exp_q.pop_front();
      p = exp_w.pop_front();
      checks++; if (bus.Fault !== f[0]) begin errors++; $display("FAIL tmo_fault c%0d got=%b want=%0d", c, bus.Fault, f); end
      checks++; if (bus.Preset !== p[0]) begin errors++; $display("FAIL tmo_preset c%0d got=%b want=%0d", c, bus.Preset, p); end
    end
    checks++; if (bus.ErrCount !== 4'd1) begin errors++; $display("FAIL tmo_err got=%0d want=1", bus.ErrCount); end
  endtask

  task automatic test_clear_vs_inc();
    do_reset();
    repeat (18) @(negedge Clock);
    checks++; if (bus.Revolutions !== 2'd3) begin errors++; $display("FAIL cvi_pre_rev got=%0d want=3", bus.Revolutions); end
    bus.Clear = 1'b1;
    @(negedge Clock);
    bus.Clear = 1'b0;
    checks++; if (bus.Revolutions !== 2'd0) begin errors++; $display("FAIL cvi_rev got=%0d want=0", bus.Revolutions); end
    checks++; if (bus.Wrap !== 1'b0) begin errors++; $display("FAIL cvi_wrap got=%b want=0", bus.Wrap); end
    checks++; if (bus.Locked !== 1'b1) begin errors++; $display("FAIL cvi_locked got=%b want=1", bus.Locked); end
    repeat (4) @(negedge Clock);
    checks++; if (bus.Revolutions !== 2'd1) begin errors++; $display("FAIL cvi_next_rev got=%0d want=1", bus.Revolutions); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    repeat (3) @(negedge Clock);
    ovr_val = 4'b0110; ovr_en = 1'b1;
    @(negedge Clock);
    repeat (2) begin
      ovr_val = 4'b0011; bus.Clear = 1'b1;
      @(negedge Clock);
      bus.Clear = 1'b0;
      @(negedge Clock);
    end
    ovr_en = 1'b0; bus.Clear = 1'b1;
    @(negedge Clock);
    bus.Clear = 1'b0;
    n = 0;
    while (bus.Locked !== 1'b1 && n < 20) begin @(negedge Clock); n++; end
    checks++; if (bus.Locked !== 1'b1) begin errors++; $display("FAIL mid_relock_timeout got=%b want=1", bus.Locked); end
    checks++; if (bus.ErrCount !== 4'd3) begin errors++; $display("FAIL mid_err got=%0d want=3", bus.ErrCount); end
    #2 Resetn = 1'b0; ring_clr = 1'b1;
    #1;
    checks++; if (bus.Locked !== 1'b0) begin errors++; $display("FAIL mid_locked got=%b want=0", bus.Locked); end
    checks++; if (bus.Fault !== 1'b0) begin errors++; $display("FAIL mid_fault got=%b want=0", bus.Fault); end
    checks++; if (bus.Preset !== 1'b0) begin errors++; $display("FAIL mid_preset got=%b want=0", bus.Preset); end
    checks++; if (bus.Slot !== 2'd0) begin errors++; $display("FAIL mid_slot got=%0d want=0", bus.Slot); end
    checks++; if (bus.Revolutions !== 2'd0) begin errors++; $display("FAIL mid_rev got=%0d want=0", bus.Revolutions); end
    checks++; if (bus.Wrap !== 1'b0) begin errors++; $display("FAIL mid_wrap got=%b want=0", bus.Wrap); end
    checks++; if (bus.ErrCount !== 4'd0) begin errors++; $display("FAIL mid_errcnt got=%0d want=0", bus.ErrCount); end
    repeat (2) @(negedge Clock);
    Resetn = 1'b1; ring_clr = 1'b0;
    @(negedge Clock);
    checks++; if (bus.Preset !== 1'b1) begin errors++; $display("FAIL mid_c1_preset got=%b want=1", bus.Preset); end
    @(negedge Clock);
    checks++; if (bus.Locked !== 1'b0) begin errors++; $display("FAIL mid_c2_locked got=%b want=0", bus.Locked); end
    @(negedge Clock);
    checks++; if (bus.Locked !== 1'b1) begin errors++; $display("FAIL mid_c3_locked got=%b want=1", bus.Locked); end
    checks++; if (bus.Slot !== 2'd2) begin errors++; $display("FAIL mid_c3_slot got=%0d want=2", bus.Slot); end
  endtask

  initial begin
    test_reset();
    test_clean_start();
    test_revolutions();
    test_illegal();
    test_timeout();
    test_clear_vs_inc();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
